// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side byte buffer sitting directly behind uart_receiver. Each good
// frame reported by the receiver is captured into a DEPTH-entry
// first-word-fall-through FIFO, so the SAP-2 program can poll the UART at its
// own pace.
//
// Ports:
//   clk              system clock, all state changes on the rising edge
//   reset            asynchronous active-low reset
//   rx_data_in       received byte, qualified by rx_data_valid
//   rx_data_valid    one-cycle pulse marking a completed frame
//   rx_frame_error   qualifies rx_data_valid: stop bit sampled low
//   cpu_rd_en        one-cycle pop strobe from the CPU data-register read
//   cpu_clr_status   one-cycle strobe clearing both sticky flags
//   data_out         head-of-FIFO byte, zero when empty
//   data_ready       FIFO not empty
//   fifo_full        count == DEPTH
//   count            number of stored entries, 0..DEPTH
//   overrun_flag     sticky: a good byte was dropped because the FIFO was full
//   frame_error_flag sticky: a frame with a bad stop bit was received
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_WIDTH-1:0]      rx_data_in,
    input  logic                       rx_data_valid,
    input  logic                       rx_frame_error,
    input  logic                       cpu_rd_en,
    input  logic                       cpu_clr_status,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       data_ready,
    output logic                       fifo_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overrun_flag,
    output logic                       frame_error_flag
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Storage is deliberately not reset; the count gates what is visible.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;

    logic          full_s;
    logic          good_byte_s;
    logic          pop_s;
    logic          push_s;
    logic          overrun_set_s;
    logic          frame_set_s;

    // Accept/reject decisions, all taken on pre-edge state.
    always_comb begin
        full_s        = (count_q == DEPTH_C);
        good_byte_s   = rx_data_valid && !rx_frame_error;
        pop_s         = cpu_rd_en && (count_q != {CW{1'b0}});
        // A full FIFO still takes a byte when the CPU frees a slot this cycle.
        push_s        = good_byte_s && (!full_s || pop_s);
        overrun_set_s = good_byte_s && full_s && !pop_s;
        frame_set_s   = rx_data_valid && rx_frame_error;
    end

    // Next-state for pointers, occupancy and sticky flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A set event in the same cycle as a clear leaves the flag set.
        if (overrun_set_s) begin
            overrun_d = 1'b1;
        end else if (cpu_clr_status) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        if (frame_set_s) begin
            frame_err_d = 1'b1;
        end else if (cpu_clr_status) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Byte storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= rx_data_in;
        end
    end

    // Fall-through read port and status decode from registered state.
    always_comb begin
        if (count_q != {CW{1'b0}}) begin
            data_out = mem_q[rd_ptr_q];
        end else begin
            data_out = {DATA_WIDTH{1'b0}};
        end
        data_ready       = (count_q != {CW{1'b0}});
        fifo_full        = full_s;
        count            = count_q;
        overrun_flag     = overrun_q;
        frame_error_flag = frame_err_q;
    end

endmodule
